// File: rtl/inv_sbox_serial.sv
// Byte-serial AES inverse S-box: captures a 128-bit state on start and
// substitutes one byte per clock (byte 0 first), pulsing done after byte 15.
module inv_sbox_serial (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] s_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] s_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [127:0] in_reg;
  logic [3:0]   cnt;

  // Inverse S-box row selected by the high nibble; the low nibble picks the
  // byte within the row, leftmost byte of each constant being column 0.
  function automatic logic [7:0] inv_byte(input logic [7:0] b);
    logic [127:0] row;
    logic [3:0]   idx;
    row = '0;
    case (b[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      4'hf: row = 128'h172b047eba77d626e169146355210c7d;
      default: row = '0;
    endcase
    idx = 4'd15 - b[3:0];
    return row[{idx, 3'b000} +: 8];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      in_reg <= '0;
      cnt    <= '0;
      s_o    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            in_reg <= s_in;
            cnt    <= '0;
            s_o    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          s_o[{cnt, 3'b000} +: 8] <= inv_byte(in_reg[{cnt, 3'b000} +: 8]);
          cnt <= cnt + 4'd1;
          // Last byte: cnt wraps naturally to 0 and the FSM returns to IDLE.
          if (cnt == 4'd15) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/inv_sbox_serial.md
# inv_sbox_serial

Byte-serial AES inverse S-box (InvSubBytes) for the decryption datapath; the decrypt-side counterpart of the encrypt-side byte-serial SubBytes stage. It captures a 128-bit state on a start pulse and substitutes one byte per clock, byte 0 (bits 7:0) first, through the FIPS-197 inverse S-box. It raises `done` once all 16 bytes are written. It sits between InvShiftRows and AddRoundKey in the decrypt round controller, which drives `start` and waits on `done`.

## Interface
- Parameters: none.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request pulse; sampled only in IDLE.
- `s_in`  in  128  state to substitute; sampled only on the accepted-start edge.
- `busy`  out  1  high while bytes are being substituted.
- `done`  out  1  one-cycle pulse; `s_o` is complete and valid.
- `s_o`  out  128  substituted state; byte k is bits [8k+7:8k].

## Operation
- Internal state:
  - `in_reg[127:0]`: captured copy of `s_in`.
  - `cnt[3:0]`: byte index.
  - FSM with two states, IDLE and RUN.
- Inverse S-box: full 256-entry constant lookup per FIPS-197, implemented as combinational case logic. No run-time table initialisation. Selected values: inv(00)=52, inv(63)=00, inv(7c)=01, inv(16)=ff, inv(ed)=53.
- IDLE, `start`=1:
  - `in_reg` <= `s_in`, `cnt` <= 0, `s_o` <= 0, `busy` <= 1.
  - Go to RUN.
- IDLE, `start`=0: hold all state; `s_o` keeps the last result.
- RUN, every edge:
  - `s_o[8*cnt +: 8]` <= inv(`in_reg[8*cnt +: 8]`).
  - `cnt` <= `cnt`+1.
- RUN, edge where `cnt`==15:
  - Write byte 15, `cnt` wraps to 0.
  - `busy` <= 0, `done` <= 1, go to IDLE.
- `done` is a registered pulse and is cleared on every other edge.
- `start` in RUN is ignored; there is no queueing.
- `s_in` changes after the accepted-start edge have no effect.
- `rst` (overrides everything, including mid-operation): `s_o`=0, `busy`=0, `done`=0, `cnt`=0, `in_reg`=0, FSM=IDLE.

## Timing
- E0 = edge at which `start` is accepted.
- Byte k is written at edge E(k+1); bytes 0..15 are written at E1..E16.
- `busy` is high from after E0 through E16, i.e. exactly 16 cycles.
- `done` is high for the single cycle after E16. Latency from start edge to `done`: 16 cycles.
- Partial results are visible: after edge Ej, bytes 0..j-1 hold substituted values and bytes j..15 read 0.
- Back-to-back: `start` asserted during the `done` cycle (FSM already IDLE) is accepted.
  - That edge clears `s_o`, so the consumer must capture `s_o` in the `done` cycle.
  - Sustained throughput: one block per 17 cycles.
- Reset asserted on any edge during RUN aborts the operation. No `done` is produced, and the next operation needs a fresh `start`.

## Test plan
- Reset: hold `rst` 2 cycles -> `s_o`=0, `busy`=0, `done`=0. `start`=1 during `rst` is not accepted.
- All-0x63 input:
  - `s_in`=128'h6363...63, pulse `start` -> `busy` high 16 cycles.
  - `done` pulses once, 16 cycles after the start edge.
  - `s_o`=128'h0.
- Mixed bytes:
  - Stimulus: byte0=63, byte1=7c, byte2=ed, byte3=00, bytes 4..15=16.
  - Expected `s_o`: byte0=00, byte1=01, byte2=53, byte3=52, bytes 4..15=ff.
  - After E2, `s_o`=128'h0100 exactly (partial-result check).
- Round-trip: 1000 random blocks through the encrypt-side SubBytes stage then this block -> output equals original input each time.
- Protocol misuse:
  - `start` pulsed at E5 of a run is ignored; `done` timing is unchanged.
  - `s_in` changed at E3 does not alter the result.
- Reset mid-operation then back-to-back:
  - `rst` at E8 -> all outputs 0 next cycle, no `done`.
  - Then two starts (second in the `done` cycle of the first) -> two correct results and two `done` pulses 17 cycles apart.
